// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_e;

   localparam int DATA_BITS    = 8;
   localparam int MIN_PRESCALE = 8;

   function automatic logic is_bit_state(rx_state_e s);
      return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_cnt.sv
// Oversample edge counter and data bit counter for the RX frame controller.
// edge_cnt wraps at last_val_i; bit_cnt advances on each wrap while bit_run_i is high.
module rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  edge_run_i,
   input  logic                  bit_run_i,
   input  logic [PRESCALE_W-1:0] last_val_i,
   output logic [PRESCALE_W-1:0] edge_cnt_o,
   output logic [3:0]            bit_cnt_o,
   output logic                  edge_last_o,
   output logic                  bit_last_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;

   assign edge_last_o = (edge_cnt_q == last_val_i);
   assign bit_last_o  = (bit_cnt_q == 4'(DATA_BITS - 1));
   assign edge_cnt_o  = edge_cnt_q;
   assign bit_cnt_o   = bit_cnt_q;

   always_comb begin
      edge_cnt_d = '0;
      if (edge_run_i && !edge_last_o) begin
         edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
      // bit_cnt falls back to 0 after the last data bit so it reads 0 outside DATA
      bit_cnt_d = '0;
      if (bit_run_i) begin
         bit_cnt_d = bit_cnt_q;
         if (edge_last_o) begin
            bit_cnt_d = bit_last_o ? 4'd0 : bit_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: tracks start/data/parity/stop at P-times oversampling,
// strobes the sampler and checkers at the sample point and reports per-frame status.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rx_in_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic                  par_en_i,
   input  logic                  strt_glitch_i,
   input  logic                  par_err_i,
   input  logic                  stp_err_i,
   output logic [PRESCALE_W-1:0] edge_cnt_o,
   output logic [3:0]            bit_cnt_o,
   output logic                  dat_samp_en_o,
   output logic                  deser_en_o,
   output logic                  strt_chk_en_o,
   output logic                  par_chk_en_o,
   output logic                  stp_chk_en_o,
   output logic                  data_valid_o,
   output logic                  parity_error_o,
   output logic                  framing_error_o
);

   rx_state_e             state_q;
   logic [PRESCALE_W-1:0] p_q;
   logic [PRESCALE_W-1:0] p_lat, last_val, samp_m1;
   logic                  edge_last, bit_last, edge_run, bit_run, at_samp;
   logic                  par_flag_q;

   assign p_lat    = (prescale_i < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : prescale_i;
   assign last_val = p_q - PRESCALE_W'(1);
   // Strobes are registered, so they are launched one edge ahead of the sample point P/2+2
   assign samp_m1  = (p_q >> 1) + PRESCALE_W'(1);
   assign at_samp  = (edge_cnt_o == samp_m1);
   assign edge_run = is_bit_state(state_q) || ((state_q == DONE) && !rx_in_i);
   assign bit_run  = (state_q == DATA);

   rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .edge_run_i  (edge_run),
      .bit_run_i   (bit_run),
      .last_val_i  (last_val),
      .edge_cnt_o  (edge_cnt_o),
      .bit_cnt_o   (bit_cnt_o),
      .edge_last_o (edge_last),
      .bit_last_o  (bit_last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         p_q             <= PRESCALE_W'(MIN_PRESCALE);
         par_flag_q      <= 1'b0;
         dat_samp_en_o   <= 1'b0;
         deser_en_o      <= 1'b0;
         strt_chk_en_o   <= 1'b0;
         par_chk_en_o    <= 1'b0;
         stp_chk_en_o    <= 1'b0;
         data_valid_o    <= 1'b0;
         parity_error_o  <= 1'b0;
         framing_error_o <= 1'b0;
      end else begin
         deser_en_o    <= 1'b0;
         strt_chk_en_o <= 1'b0;
         par_chk_en_o  <= 1'b0;
         stp_chk_en_o  <= 1'b0;
         data_valid_o  <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (!rx_in_i) begin
                  state_q         <= START;
                  p_q             <= p_lat;
                  par_flag_q      <= 1'b0;
                  parity_error_o  <= 1'b0;
                  framing_error_o <= 1'b0;
                  dat_samp_en_o   <= 1'b1;
               end else begin
                  state_q       <= IDLE;
                  dat_samp_en_o <= 1'b0;
               end
            end
            START: begin
               if (at_samp) strt_chk_en_o <= 1'b1;
               if (edge_last) begin
                  if (strt_glitch_i) begin
                     state_q       <= IDLE;
                     dat_samp_en_o <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (at_samp) deser_en_o <= 1'b1;
               if (edge_last && bit_last) state_q <= par_en_i ? PARITY : STOP;
            end
            PARITY: begin
               if (at_samp) par_chk_en_o <= 1'b1;
               if (edge_last) begin
                  par_flag_q <= par_flag_q | par_err_i;
                  state_q    <= STOP;
               end
            end
            STOP: begin
               if (at_samp) stp_chk_en_o <= 1'b1;
               if (edge_last) begin
                  state_q         <= DONE;
                  dat_samp_en_o   <= 1'b0;
                  data_valid_o    <= !(par_flag_q || stp_err_i);
                  parity_error_o  <= par_flag_q;
                  framing_error_o <= stp_err_i;
               end
            end
            default: begin
               state_q       <= IDLE;
               dat_samp_en_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed plus randomized frames against a frame-level timing/status model.
module tb_uart_rx_ctrl;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         rx_in = 1'b1;
   logic [W-1:0] prescale = W'(8);
   logic         par_en = 1'b0;
   logic         strt_glitch = 1'b0;
   logic         par_err = 1'b0;
   logic         stp_err = 1'b0;
   logic [W-1:0] edge_cnt;
   logic [3:0]   bit_cnt;
   logic         dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
   logic         data_valid, parity_error, framing_error;
   logic [W+11:0] all_out;

   uart_rx_ctrl #(.PRESCALE_W(W)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rx_in_i         (rx_in),
      .prescale_i      (prescale),
      .par_en_i        (par_en),
      .strt_glitch_i   (strt_glitch),
      .par_err_i       (par_err),
      .stp_err_i       (stp_err),
      .edge_cnt_o      (edge_cnt),
      .bit_cnt_o       (bit_cnt),
      .dat_samp_en_o   (dat_samp_en),
      .deser_en_o      (deser_en),
      .strt_chk_en_o   (strt_chk_en),
      .par_chk_en_o    (par_chk_en),
      .stp_chk_en_o    (stp_chk_en),
      .data_valid_o    (data_valid),
      .parity_error_o  (parity_error),
      .framing_error_o (framing_error)
   );

   assign all_out = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                     stp_chk_en, data_valid, parity_error, framing_error};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: cumulative counts sampled mid-cycle
   int cur_p = 8;
   int n_deser = 0, n_strobe_bad = 0, n_bit_bad = 0, n_par_chk = 0, n_strt_chk = 0;
   int n_stp_chk = 0, n_samp = 0, n_dv = 0, last_samp = 0, mon_bit = 0;
   int dv_times[$];

   always @(negedge clk) begin
      if (!rst) begin
         if ((deser_en || strt_chk_en || par_chk_en || stp_chk_en) && (int'(edge_cnt) != cur_p / 2 + 2))
            n_strobe_bad++;
         if (strt_chk_en) begin
            n_strt_chk++;
            mon_bit = 0;
         end
         if (deser_en) begin
            n_deser++;
            if (int'(bit_cnt) != mon_bit) n_bit_bad++;
            mon_bit++;
         end
         if (par_chk_en) n_par_chk++;
         if (stp_chk_en) n_stp_chk++;
         if (dat_samp_en) begin
            n_samp++;
            last_samp = cyc;
         end
         if (data_valid) begin
            n_dv++;
            dv_times.push_back(cyc + 1);
         end
      end
   end

   int n_pass = 0, n_checks = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Drives one frame on the line; t0 is the edge that first samples the start bit.
   task automatic send_frame(input logic [7:0] b, input int pin, input bit pe, output int t0);
      logic [10:0] bits;
      int p, nb;
      p     = (pin < 8) ? 8 : pin;
      nb    = pe ? 11 : 10;
      bits  = pe ? {1'b1, ^b, b, 1'b0} : {1'b1, 1'b1, b, 1'b0};
      cur_p = p;
      prescale = W'(pin);
      par_en   = pe;
      t0 = 0;
      for (int k = 0; k < nb; k++) begin
         rx_in = bits[k];
         if (k == 0) begin
            @(negedge clk);
            t0 = cyc;
            @(negedge clk);
            prescale = W'($urandom_range(0, 63));
            repeat (p - 2) @(negedge clk);
         end else begin
            repeat (p) @(negedge clk);
         end
      end
      rx_in = 1'b1;
   endtask

   task automatic run_frame(input int pin, input bit pe, input bit perr, input bit serr,
                            input logic [7:0] b, input string nm);
      int p, nb, t0, exp_dv, lat;
      int s_deser, s_bad, s_bit, s_par, s_strt, s_stp, s_samp, s_dv;
      p      = (pin < 8) ? 8 : pin;
      nb     = pe ? 11 : 10;
      exp_dv = (!(pe && perr) && !serr) ? 1 : 0;
      par_err = perr;
      stp_err = serr;
      s_deser = n_deser; s_bad = n_strobe_bad; s_bit = n_bit_bad; s_par = n_par_chk;
      s_strt = n_strt_chk; s_stp = n_stp_chk; s_samp = n_samp; s_dv = n_dv;
      send_frame(b, pin, pe, t0);
      repeat (4) @(negedge clk);
      check({nm, " deser_cnt"}, n_deser - s_deser, 8);
      check({nm, " strobe_pos"}, n_strobe_bad - s_bad, 0);
      check({nm, " deser_bit_idx"}, n_bit_bad - s_bit, 0);
      check({nm, " par_chk_cnt"}, n_par_chk - s_par, pe ? 1 : 0);
      check({nm, " strt_chk_cnt"}, n_strt_chk - s_strt, 1);
      check({nm, " stp_chk_cnt"}, n_stp_chk - s_stp, 1);
      check({nm, " samp_cycles"}, n_samp - s_samp, nb * p);
      check({nm, " dv_cnt"}, n_dv - s_dv, exp_dv);
      check({nm, " parity_error"}, parity_error, (pe && perr) ? 1 : 0);
      check({nm, " framing_error"}, framing_error, serr ? 1 : 0);
      check({nm, " idle_edge_cnt"}, edge_cnt, 0);
      if (exp_dv == 1) begin
         lat = (dv_times.size() > 0) ? dv_times[$] - t0 : -1;
         check({nm, " dv_latency"}, lat, 1 + nb * p);
      end
      par_err = 1'b0;
      stp_err = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int ta, tb2, base, diff, t0, s_deser, s_dv, s_samp, s_strt, s_stp, pin;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_out, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_outputs", all_out, 0);

      run_frame(8, 1'b1, 1'b0, 1'b0, 8'hA5, "p8_par_a5");
      run_frame(16, 1'b0, 1'b0, 1'b0, 8'h3C, "p16_nopar_3c");
      run_frame(8, 1'b1, 1'b1, 1'b0, 8'h5A, "par_err");
      run_frame(8, 1'b1, 1'b0, 1'b1, 8'h0F, "stp_err");
      run_frame(16, 1'b0, 1'b1, 1'b0, 8'h81, "par_err_ignored");
      run_frame(4, 1'b1, 1'b0, 1'b0, 8'hC3, "clamp_p4");

      // Start-bit glitch
      strt_glitch = 1'b1;
      s_deser = n_deser; s_dv = n_dv; s_samp = n_samp; s_strt = n_strt_chk; s_stp = n_stp_chk;
      prescale = W'(16);
      cur_p = 16;
      rx_in = 1'b0;
      @(negedge clk);
      t0 = cyc;
      repeat (2) @(negedge clk);
      rx_in = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch samp_cycles", n_samp - s_samp, 16);
      check("glitch last_samp", last_samp - t0, 15);
      check("glitch deser_cnt", n_deser - s_deser, 0);
      check("glitch dv_cnt", n_dv - s_dv, 0);
      check("glitch strt_chk_cnt", n_strt_chk - s_strt, 1);
      check("glitch stp_chk_cnt", n_stp_chk - s_stp, 0);
      check("glitch status", {parity_error, framing_error}, 0);
      strt_glitch = 1'b0;
      repeat (2) @(negedge clk);

      // Back-to-back frames
      base = dv_times.size();
      send_frame(8'h12, 8, 1'b1, ta);
      send_frame(8'hED, 8, 1'b1, tb2);
      repeat (4) @(negedge clk);
      check("b2b dv_cnt", dv_times.size() - base, 2);
      diff = (dv_times.size() >= base + 2) ? dv_times[base + 1] - dv_times[base] : -1;
      check("b2b dv_spacing", diff, 88);
      repeat (3) @(negedge clk);

      // Reset in the middle of DATA
      prescale = W'(8);
      cur_p = 8;
      par_en = 1'b1;
      rx_in = 1'b0;
      @(negedge clk);
      rx_in = 1'b1;
      for (int i = 0; i < 200 && bit_cnt != 4'd4; i++) @(negedge clk);
      check("midreset reached_bit4", bit_cnt, 4);
      rst = 1'b1;
      @(negedge clk);
      check("midreset outputs", all_out, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset idle", all_out, 0);
      run_frame(8, 1'b1, 1'b0, 1'b0, 8'h96, "post_reset");

      for (int n = 0; n < 8; n++) begin
         pin = 8 << $urandom_range(0, 2);
         run_frame(pin, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 8'($urandom), $sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
